// File: rtl/biu_arb_if.sv
// Bus bundle for the fetch/load-store arbiter: both requester ports, the shared
// memory port and the busy flag. The slave modport is the arbiter's view.
interface biu_arb_if;
    // Fetch requester
    logic        hs_if4bi_val;
    logic        hs_bi4if_rdy;
    logic [31:0] i_if_adr;
    logic        hs_bi4if_rval;
    logic [31:0] o_if_rdat;
    // Load/store requester
    logic        hs_ls4bi_val;
    logic        hs_bi4ls_rdy;
    logic [31:0] i_ls_adr;
    logic [31:0] i_ls_wdat;
    logic [3:0]  i_ls_wen;
    logic        i_ls_ren;
    logic        hs_bi4ls_rval;
    logic [31:0] o_ls_rdat;
    // Shared memory port
    logic        o_mem_val;
    logic        i_mem_rdy;
    logic [31:0] o_mem_adr;
    logic [31:0] o_mem_wdat;
    logic [3:0]  o_mem_wen;
    logic        i_mem_rval;
    logic [31:0] i_mem_rdat;
    logic        o_busy;

    modport slave (
        input  hs_if4bi_val, i_if_adr,
        output hs_bi4if_rdy, hs_bi4if_rval, o_if_rdat,
        input  hs_ls4bi_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
        output hs_bi4ls_rdy, hs_bi4ls_rval, o_ls_rdat,
        output o_mem_val, o_mem_adr, o_mem_wdat, o_mem_wen,
        input  i_mem_rdy, i_mem_rval, i_mem_rdat,
        output o_busy
    );

    modport master (
        output hs_if4bi_val, i_if_adr,
        input  hs_bi4if_rdy, hs_bi4if_rval, o_if_rdat,
        output hs_ls4bi_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
        input  hs_bi4ls_rdy, hs_bi4ls_rval, o_ls_rdat,
        input  o_mem_val, o_mem_adr, o_mem_wdat, o_mem_wen,
        output i_mem_rdy, i_mem_rval, i_mem_rdat,
        input  o_busy
    );
endinterface

// File: rtl/biu_arb.sv
// Single-outstanding memory port arbiter between instruction fetch and
// load/store, with a starvation counter that eventually forces a fetch grant.
module biu_arb #(
    parameter int STARVE_MAX = 4,
    localparam int SW = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    biu_arb_if.slave      bus,
    output logic          dbg_state_o,
    output logic [SW-1:0] dbg_starve_o,
    output logic          dbg_rd_o
);
    // Handshake: a request transfers on the cycle where o_mem_val & i_mem_rdy;
    // the winner's rdy mirrors i_mem_rdy in that same cycle, and exactly one
    // i_mem_rval later completes it. rval outputs are one-cycle pulses.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rd_q, rd_d;
    logic          busy_q;
    logic          if_rval_q, ls_rval_q;
    logic [31:0]   if_rdat_q, ls_rdat_q;

    logic starve_at_max;
    logic fetch_win;
    logic ls_win;
    logic rsp;

    assign starve_at_max = (starve_q == SW'(STARVE_MAX));
    assign rsp           = (state_q == WAIT) && bus.i_mem_rval;

    always_comb begin
        state_d            = state_q;
        owner_d            = owner_q;
        starve_d           = starve_q;
        rd_d               = rd_q;
        fetch_win          = 1'b0;
        ls_win             = 1'b0;
        bus.o_mem_val      = 1'b0;
        bus.o_mem_adr      = 32'h0;
        bus.o_mem_wdat     = 32'h0;
        bus.o_mem_wen      = 4'h0;
        bus.hs_bi4if_rdy   = 1'b0;
        bus.hs_bi4ls_rdy   = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    fetch_win = bus.hs_if4bi_val && (!bus.hs_ls4bi_val || starve_at_max);
                    ls_win    = bus.hs_ls4bi_val && !fetch_win;
                    if (fetch_win) begin
                        bus.o_mem_val    = 1'b1;
                        bus.o_mem_adr    = bus.i_if_adr;
                        bus.hs_bi4if_rdy = bus.i_mem_rdy;
                        if (bus.i_mem_rdy) begin
                            state_d  = WAIT;
                            owner_d  = OWN_IF;
                            starve_d = '0;
                            rd_d     = 1'b1;
                        end
                    end else if (ls_win) begin
                        bus.o_mem_val    = 1'b1;
                        bus.o_mem_adr    = bus.i_ls_adr;
                        bus.o_mem_wdat   = bus.i_ls_wdat;
                        bus.o_mem_wen    = bus.i_ls_wen;
                        bus.hs_bi4ls_rdy = bus.i_mem_rdy;
                        if (bus.i_mem_rdy) begin
                            state_d = WAIT;
                            owner_d = OWN_LS;
                            rd_d    = bus.i_ls_ren && (bus.i_ls_wen == 4'h0);
                            // Only count grants that actually made fetch wait
                            if (bus.hs_if4bi_val && !starve_at_max) begin
                                starve_d = starve_q + SW'(1);
                            end
                        end
                    end
                end
                WAIT: begin
                    if (bus.i_mem_rval) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            starve_q  <= '0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            if_rval_q <= 1'b0;
            ls_rval_q <= 1'b0;
            if_rdat_q <= 32'h0;
            ls_rdat_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            rd_q      <= rd_d;
            busy_q    <= (state_d == WAIT);
            if_rval_q <= rsp && (owner_q == OWN_IF);
            ls_rval_q <= rsp && (owner_q == OWN_LS);
            if (rsp && (owner_q == OWN_IF)) begin
                if_rdat_q <= bus.i_mem_rdat;
            end
            if (rsp && (owner_q == OWN_LS)) begin
                ls_rdat_q <= bus.i_mem_rdat;
            end
        end
    end

    assign bus.hs_bi4if_rval = if_rval_q;
    assign bus.hs_bi4ls_rval = ls_rval_q;
    assign bus.o_if_rdat     = if_rdat_q;
    assign bus.o_ls_rdat     = ls_rdat_q;
    assign bus.o_busy        = busy_q;

    assign dbg_state_o  = state_q;
    assign dbg_starve_o = starve_q;
    assign dbg_rd_o     = rd_q;
endmodule

// File: tb/tb_biu_arb.sv
// Directed bench for biu_arb: single fetch, priority, starvation, back-pressure,
// reset during WAIT and stray responses, each with hand-computed expectations.
module tb_biu_arb;
    logic       clk;
    logic       rst;
    logic       dbg_state;
    logic [2:0] dbg_starve;
    logic       dbg_rd;

    int n_checks;
    int n_fail;

    biu_arb_if bus ();

    biu_arb #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .dbg_state_o  (dbg_state),
        .dbg_starve_o (dbg_starve),
        .dbg_rd_o     (dbg_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [31:0] data);
        bus.i_mem_rval = 1'b1;
        bus.i_mem_rdat = data;
        step();
        bus.i_mem_rval = 1'b0;
        bus.i_mem_rdat = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.hs_if4bi_val = 1'b0;
        bus.i_if_adr     = 32'h0;
        bus.hs_ls4bi_val = 1'b0;
        bus.i_ls_adr     = 32'h0;
        bus.i_ls_wdat    = 32'h0;
        bus.i_ls_wen     = 4'h0;
        bus.i_ls_ren     = 1'b0;
        bus.i_mem_rdy    = 1'b0;
        bus.i_mem_rval   = 1'b0;
        bus.i_mem_rdat   = 32'h0;

        // Reset state, with a request pending that must be masked
        step();
        step();
        bus.hs_if4bi_val = 1'b1;
        bus.i_mem_rdy    = 1'b1;
        #1;
        chk("rst_mem_val", 32'(bus.o_mem_val), 32'h0);
        chk("rst_if_rdy", 32'(bus.hs_bi4if_rdy), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_if_rdat", bus.o_if_rdat, 32'h0);
        chk("rst_ls_rdat", bus.o_ls_rdat, 32'h0);
        chk("rst_starve", 32'(dbg_starve), 32'h0);
        bus.hs_if4bi_val = 1'b0;
        bus.i_mem_rdy    = 1'b0;
        step();
        rst = 1'b0;

        // Single fetch
        bus.hs_if4bi_val = 1'b1;
        bus.i_if_adr     = 32'h100;
        bus.i_mem_rdy    = 1'b1;
        #1;
        chk("f_mem_val", 32'(bus.o_mem_val), 32'h1);
        chk("f_mem_adr", bus.o_mem_adr, 32'h100);
        chk("f_mem_wen", 32'(bus.o_mem_wen), 32'h0);
        chk("f_if_rdy", 32'(bus.hs_bi4if_rdy), 32'h1);
        chk("f_ls_rdy", 32'(bus.hs_bi4ls_rdy), 32'h0);
        step();
        bus.hs_if4bi_val = 1'b0;
        bus.i_mem_rdy    = 1'b0;
        chk("f_wait_busy", 32'(bus.o_busy), 32'h1);
        chk("f_wait_val", 32'(bus.o_mem_val), 32'h0);
        step();
        chk("f_wait_rval", 32'(bus.hs_bi4if_rval), 32'h0);
        respond(32'hDEADBEEF);
        chk("f_rval", 32'(bus.hs_bi4if_rval), 32'h1);
        chk("f_rdat", bus.o_if_rdat, 32'hDEADBEEF);
        chk("f_ls_rdat_keep", bus.o_ls_rdat, 32'h0);
        chk("f_busy_done", 32'(bus.o_busy), 32'h0);
        step();
        chk("f_rval_pulse", 32'(bus.hs_bi4if_rval), 32'h0);

        // Both valid: store wins, fetch follows
        bus.hs_if4bi_val = 1'b1;
        bus.i_if_adr     = 32'h300;
        bus.hs_ls4bi_val = 1'b1;
        bus.i_ls_adr     = 32'h200;
        bus.i_ls_wdat    = 32'h12345678;
        bus.i_ls_wen     = 4'hF;
        bus.i_mem_rdy    = 1'b1;
        #1;
        chk("p_mem_adr", bus.o_mem_adr, 32'h200);
        chk("p_mem_wen", 32'(bus.o_mem_wen), 32'hF);
        chk("p_mem_wdat", bus.o_mem_wdat, 32'h12345678);
        chk("p_ls_rdy", 32'(bus.hs_bi4ls_rdy), 32'h1);
        chk("p_if_rdy", 32'(bus.hs_bi4if_rdy), 32'h0);
        step();
        bus.hs_ls4bi_val = 1'b0;
        chk("p_starve1", 32'(dbg_starve), 32'h1);
        chk("p_wait_if_rdy", 32'(bus.hs_bi4if_rdy), 32'h0);
        step();
        respond(32'hA5A5A5A5);
        chk("p_ls_rval", 32'(bus.hs_bi4ls_rval), 32'h1);
        chk("p_ls_rdat", bus.o_ls_rdat, 32'hA5A5A5A5);
        chk("p_if_rdat_keep", bus.o_if_rdat, 32'hDEADBEEF);
        #1;
        chk("p_f_reissue_adr", bus.o_mem_adr, 32'h300);
        chk("p_f_reissue_rdy", 32'(bus.hs_bi4if_rdy), 32'h1);
        chk("p_f_reissue_wen", 32'(bus.o_mem_wen), 32'h0);
        step();
        bus.hs_if4bi_val = 1'b0;
        chk("p_starve0", 32'(dbg_starve), 32'h0);
        step();
        respond(32'h11112222);
        chk("p_if_rdat", bus.o_if_rdat, 32'h11112222);
        chk("p_ls_rdat_keep", bus.o_ls_rdat, 32'hA5A5A5A5);

        // Starvation: 4 loads then a forced fetch
        bus.hs_if4bi_val = 1'b1;
        bus.i_if_adr     = 32'h400;
        bus.hs_ls4bi_val = 1'b1;
        bus.i_ls_adr     = 32'h500;
        bus.i_ls_wen     = 4'h0;
        bus.i_ls_ren     = 1'b1;
        bus.i_mem_rdy    = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk($sformatf("s_adr%0d", g), bus.o_mem_adr, (g < 4) ? 32'h500 : 32'h400);
            chk($sformatf("s_if_rdy%0d", g), 32'(bus.hs_bi4if_rdy), (g < 4) ? 32'h0 : 32'h1);
            step();
            chk($sformatf("s_starve%0d", g), 32'(dbg_starve), (g < 4) ? 32'(g + 1) : 32'h0);
            respond(32'hC000_0000 + 32'(g));
            if (g == 4) begin
                bus.hs_if4bi_val = 1'b0;
                bus.hs_ls4bi_val = 1'b0;
                bus.i_mem_rdy    = 1'b0;
            end
        end
        chk("s_if_rdat", bus.o_if_rdat, 32'hC000_0004);
        chk("s_ls_rdat", bus.o_ls_rdat, 32'hC000_0003);

        // Back-pressure: held in IDLE, winner switches to load/store
        bus.hs_if4bi_val = 1'b1;
        bus.i_if_adr     = 32'h600;
        #1;
        chk("b_val", 32'(bus.o_mem_val), 32'h1);
        chk("b_adr", bus.o_mem_adr, 32'h600);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("b_hold_val%0d", c), 32'(bus.o_mem_val), 32'h1);
            chk($sformatf("b_hold_rdy%0d", c), 32'({bus.hs_bi4if_rdy, bus.hs_bi4ls_rdy}), 32'h0);
            chk($sformatf("b_hold_state%0d", c), 32'(dbg_state), 32'h0);
        end
        bus.hs_ls4bi_val = 1'b1;
        bus.i_ls_adr     = 32'h700;
        #1;
        chk("b_switch_adr", bus.o_mem_adr, 32'h700);
        chk("b_switch_rdy", 32'(bus.hs_bi4ls_rdy), 32'h0);
        bus.hs_if4bi_val = 1'b0;
        bus.hs_ls4bi_val = 1'b0;
        #1;
        chk("b_none_val", 32'(bus.o_mem_val), 32'h0);
        chk("b_none_adr", bus.o_mem_adr, 32'h0);

        // Reset during WAIT, then a stray response
        bus.hs_if4bi_val = 1'b1;
        bus.i_if_adr     = 32'h800;
        bus.i_mem_rdy    = 1'b1;
        step();
        bus.hs_if4bi_val = 1'b0;
        bus.i_mem_rdy    = 1'b0;
        chk("r_busy_pre", 32'(bus.o_busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r_busy", 32'(bus.o_busy), 32'h0);
        chk("r_state", 32'(dbg_state), 32'h0);
        chk("r_if_rdat", bus.o_if_rdat, 32'h0);
        chk("r_ls_rdat", bus.o_ls_rdat, 32'h0);
        respond(32'h77777777);
        chk("r_stray_if_rval", 32'(bus.hs_bi4if_rval), 32'h0);
        chk("r_stray_ls_rval", 32'(bus.hs_bi4ls_rval), 32'h0);
        chk("r_stray_if_rdat", bus.o_if_rdat, 32'h0);

        // Partial store, then a stray response in IDLE
        bus.hs_ls4bi_val = 1'b1;
        bus.i_ls_adr     = 32'h900;
        bus.i_ls_wdat    = 32'hCAFEF00D;
        bus.i_ls_wen     = 4'h3;
        bus.i_mem_rdy    = 1'b1;
        #1;
        chk("i_wen", 32'(bus.o_mem_wen), 32'h3);
        chk("i_wdat", bus.o_mem_wdat, 32'hCAFEF00D);
        step();
        bus.hs_ls4bi_val = 1'b0;
        bus.i_mem_rdy    = 1'b0;
        respond(32'h0BADF00D);
        chk("i_ls_rdat", bus.o_ls_rdat, 32'h0BADF00D);
        step();
        respond(32'hFFFFFFFF);
        chk("i_stray_ls_rval", 32'(bus.hs_bi4ls_rval), 32'h0);
        chk("i_stray_if_rval", 32'(bus.hs_bi4if_rval), 32'h0);
        chk("i_stray_ls_rdat", bus.o_ls_rdat, 32'h0BADF00D);
        chk("i_stray_if_rdat", bus.o_if_rdat, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/biu_arb.md
BIU_ARB -- requirements
Module: biu_arb

Interface
- REQ-001: Parameter STARVE_MAX, default 4, SHALL set the number of consecutive load/store grants tolerated while fetch waits.
- REQ-002: clk  in  1  sole clock; all state SHALL update on its rising edge.
- REQ-003: rst  in  1  reset, synchronous and active-high.
- REQ-004: hs_if4bi_val  in  1  fetch request valid; hs_bi4if_rdy  out  1  fetch request accepted.
- REQ-005: i_if_adr  in  32  fetch address (read only).
- REQ-006: hs_bi4if_rval  out  1  fetch response pulse; o_if_rdat  out  32  fetch read data.
- REQ-007: hs_ls4bi_val  in  1  load/store request valid; hs_bi4ls_rdy  out  1  load/store request accepted.
- REQ-008: i_ls_adr  in  32, i_ls_wdat  in  32, i_ls_wen  in  4, i_ls_ren  in  1  load/store address, write data, byte enables, read enable.
- REQ-009: hs_bi4ls_rval  out  1  load/store response pulse; o_ls_rdat  out  32  load read data.
- REQ-010: o_mem_val  out  1, i_mem_rdy  in  1  memory request handshake; o_mem_adr  out  32, o_mem_wdat  out  32, o_mem_wen  out  4  memory request fields.
- REQ-011: i_mem_rval  in  1, i_mem_rdat  in  32  memory response (one per accepted request, reads and writes).
- REQ-012: o_busy  out  1  high while a memory transaction is outstanding.

Function
- REQ-013: The block SHALL share one memory port between fetch and load/store with at most one outstanding transaction, using states IDLE and WAIT.
- REQ-014: In IDLE with any request valid, the block SHALL select a winner combinationally, drive o_mem_val=1 with the winner's fields, and drive the winner's rdy = i_mem_rdy; the loser's rdy SHALL be 0.
- REQ-015: Fetch requests SHALL drive o_mem_wen=0 and o_mem_wdat=0; load/store requests SHALL pass i_ls_wen/i_ls_wdat unchanged; o_mem_wen=0 SHALL denote a read.
- REQ-016: Priority: load/store SHALL win when both are valid, except when starve_cnt==STARVE_MAX, in which case fetch SHALL win.
- REQ-017: starve_cnt SHALL increment (saturating at STARVE_MAX) on each accepted load/store request while hs_if4bi_val=1, and SHALL clear to 0 on each accepted fetch request.
- REQ-018: On o_mem_val & i_mem_rdy in IDLE, the block SHALL record the owner and enter WAIT next cycle; without i_mem_rdy it SHALL stay in IDLE and re-arbitrate every cycle.
- REQ-019: In WAIT, o_mem_val and both rdy outputs SHALL be 0 and o_busy SHALL be 1.
- REQ-020: On i_mem_rval in WAIT, the block SHALL register i_mem_rdat into the owner's rdat, pulse the owner's rval for exactly the following cycle, and return to IDLE in that same following cycle.
- REQ-021: A new request SHALL NOT be issued in the cycle i_mem_rval is observed; the earliest re-issue is the next cycle (rval cycle).
- REQ-022: o_if_rdat/o_ls_rdat SHALL hold their last value until that requester's next response; the non-owner's rdat SHALL be unchanged.
- REQ-023: i_mem_rval in IDLE SHALL be ignored (no rval pulse, no data update).
- REQ-024: All outputs other than registered rval/rdat/o_busy SHALL be combinational from state and inputs; all request outputs SHALL be 0 when no request is valid.

Reset
- REQ-025: While rst=1 the block SHALL enter IDLE, clear starve_cnt, owner, both rval and both rdat to 0, and o_busy to 0; request outputs SHALL be 0.
- REQ-026: Reset during WAIT SHALL drop the outstanding transaction; a subsequent i_mem_rval SHALL be ignored.

Verification
- REQ-027: Fetch only, adr 0x100, i_mem_rdy=1, i_mem_rval 2 cycles later with 0xDEADBEEF -> o_mem_adr=0x100, wen=0; hs_bi4if_rval=1 one cycle after i_mem_rval, o_if_rdat=0xDEADBEEF; o_ls_rdat unchanged.
- REQ-028: Both valid, SW adr 0x200 wdat 0x12345678 wen 0xF -> load/store granted first, o_mem_wen=0xF; fetch granted after hs_bi4ls_rval.
- REQ-029: Load/store continuously valid with fetch valid, STARVE_MAX=4 -> 4 load/store grants, then 1 fetch grant, counter back to 0.
- REQ-030: i_mem_rdy=0 for 3 cycles -> o_mem_val held, rdy outputs 0, state IDLE; winner switches if priority changes.
- REQ-031: rst pulse in WAIT then stray i_mem_rval -> no rval pulse, o_busy=0, rdat=0.
- REQ-032: i_mem_rval asserted in IDLE with 0xFFFFFFFF -> both rval stay 0, rdat unchanged.
